// File: rtl/wb_master_agent.sv
// Single-word Wishbone classic (B3) bus master driven by a start/done command port.
// Each accepted command becomes exactly one CYC/STB bus cycle ending on ACK, ERR or timeout.
module wb_master_agent #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic                    i_we,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   output logic                    o_done,
   output logic [DATA_WIDTH-1:0]   o_rdata,
   output logic                    o_err,
   output logic                    o_busy,
   output logic                    o_wb_cyc,
   output logic                    o_wb_stb,
   output logic                    o_wb_we,
   output logic [ADDR_WIDTH-1:0]   o_wb_adr,
   output logic [DATA_WIDTH-1:0]   o_wb_dat,
   output logic [DATA_WIDTH/8-1:0] o_wb_sel,
   input  logic [DATA_WIDTH-1:0]   i_wb_dat,
   input  logic                    i_wb_ack,
   input  logic                    i_wb_err
);

   localparam int SEL_W = DATA_WIDTH / 8;
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   // Count value seen on the last permitted BUS cycle; abort happens at that edge.
   localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    cyc_q, cyc_d;
   logic                    stb_q, stb_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
   logic [DATA_WIDTH-1:0]   dat_q, dat_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic                    busy_q, busy_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    timeout_hit;

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cyc_d   = cyc_q;
      stb_d   = stb_q;
      we_d    = we_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      done_d  = 1'b0;
      err_d   = err_q;
      rdata_d = rdata_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (i_start) begin
               state_d = ST_BUS;
               cnt_d   = '0;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = i_we;
               adr_d   = i_addr;
               dat_d   = i_we ? i_wdata : '0;
               sel_d   = '1;
               err_d   = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_BUS: begin
            // ERR wins over ACK when a slave raises both.
            if (i_wb_ack || i_wb_err) begin
               state_d = ST_DONE;
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               sel_d   = '0;
               done_d  = 1'b1;
               err_d   = i_wb_err;
               if (!i_wb_err && !we_q) begin
                  rdata_d = i_wb_dat;
               end
            end else if (timeout_hit) begin
               state_d = ST_DONE;
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               sel_d   = '0;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else if (TIMEOUT_CYCLES != 0) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            sel_d   = '0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         rdata_q <= rdata_d;
      end
   end

   assign o_done   = done_q;
   assign o_rdata  = rdata_q;
   assign o_err    = err_q;
   assign o_busy   = busy_q;
   assign o_wb_cyc = cyc_q;
   assign o_wb_stb = stb_q;
   assign o_wb_we  = we_q;
   assign o_wb_adr = adr_q;
   assign o_wb_dat = dat_q;
   assign o_wb_sel = sel_q;

endmodule

// File: tb/tb_wb_master_agent.sv
// Randomized bench for wb_master_agent: a scripted Wishbone slave plus a per-command
// reference model that predicts completion cycle, status and read data.
module tb_wb_master_agent;

   localparam int TO = 8;

   localparam int R_ACK    = 0;
   localparam int R_ERR    = 1;
   localparam int R_BOTH   = 2;
   localparam int R_SILENT = 3;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_start = 1'b0;
   logic        i_we = 1'b0;
   logic [31:0] i_addr = '0;
   logic [31:0] i_wdata = '0;
   logic        o_done;
   logic [31:0] o_rdata;
   logic        o_err;
   logic        o_busy;
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic        o_wb_we;
   logic [31:0] o_wb_adr;
   logic [31:0] o_wb_dat;
   logic [3:0]  o_wb_sel;
   logic [31:0] i_wb_dat = '0;
   logic        i_wb_ack = 1'b0;
   logic        i_wb_err = 1'b0;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_rdata = '0;
   logic        exp_err = 1'b0;

   always #5 clk = ~clk;

   wb_master_agent #(
      .DATA_WIDTH    (32),
      .ADDR_WIDTH    (32),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk   (clk),
      .i_rst   (i_rst),
      .i_start (i_start),
      .i_we    (i_we),
      .i_addr  (i_addr),
      .i_wdata (i_wdata),
      .o_done  (o_done),
      .o_rdata (o_rdata),
      .o_err   (o_err),
      .o_busy  (o_busy),
      .o_wb_cyc(o_wb_cyc),
      .o_wb_stb(o_wb_stb),
      .o_wb_we (o_wb_we),
      .o_wb_adr(o_wb_adr),
      .o_wb_dat(o_wb_dat),
      .o_wb_sel(o_wb_sel),
      .i_wb_dat(i_wb_dat),
      .i_wb_ack(i_wb_ack),
      .i_wb_err(i_wb_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
      end
   endtask

   // Issues a command at the current negedge and follows it to its o_done cycle.
   // Returns at the negedge where o_done is expected, so a caller may chain back-to-back.
   task automatic run_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int wait_n, input int resp, input logic [31:0] rd);
      int done_at;
      logic [31:0] exp_dat;
      i_start  = 1'b1;
      i_we     = we;
      i_addr   = addr;
      i_wdata  = wdata;
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      exp_dat  = we ? wdata : 32'h0;
      done_at  = (resp == R_SILENT) ? TO + 1 : wait_n + 2;
      for (int j = 1; j <= done_at; j++) begin
         @(negedge clk);
         i_start  = 1'b0;
         i_wb_ack = 1'b0;
         i_wb_err = 1'b0;
         if (j < done_at) begin
            check("bus_cyc", o_wb_cyc, 1);
            check("bus_stb", o_wb_stb, 1);
            check("bus_busy", o_busy, 1);
            check("bus_done", o_done, 0);
            check("bus_err_clr", o_err, 0);
            check("bus_adr", o_wb_adr, addr);
            check("bus_dat", o_wb_dat, exp_dat);
            check("bus_we", o_wb_we, we);
            check("bus_sel", o_wb_sel, 4'hF);
            if ($urandom_range(0, 3) == 0) begin
               i_start = 1'b1;
               i_we    = ~we;
               i_addr  = $urandom;
               i_wdata = $urandom;
            end
            if (resp != R_SILENT && j > wait_n) begin
               i_wb_dat = rd;
               i_wb_ack = (resp != R_ERR);
               i_wb_err = (resp != R_ACK);
            end else begin
               i_wb_dat = $urandom;
            end
         end else begin
            exp_err = (resp != R_ACK);
            if (resp == R_ACK && !we) exp_rdata = rd;
            check("done_pulse", o_done, 1);
            check("done_err", o_err, exp_err);
            check("done_rdata", o_rdata, exp_rdata);
            check("done_cyc", o_wb_cyc, 0);
            check("done_stb", o_wb_stb, 0);
            check("done_sel", o_wb_sel, 0);
            check("done_busy", o_busy, 1);
            if (resp == R_SILENT) begin
               i_wb_ack = 1'b1;
               i_wb_dat = $urandom;
            end
         end
      end
   endtask

   task automatic idle_cyc();
      @(negedge clk);
      i_start  = 1'b0;
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      check("idle_done", o_done, 0);
      check("idle_busy", o_busy, 0);
      check("idle_cyc", o_wb_cyc, 0);
      check("idle_err_hold", o_err, exp_err);
      check("idle_rdata_hold", o_rdata, exp_rdata);
      if ($urandom_range(0, 2) == 0) begin
         i_wb_ack = $urandom_range(0, 1) == 1;
         i_wb_err = $urandom_range(0, 1) == 1;
         i_wb_dat = $urandom;
      end
   endtask

   task automatic mid_reset();
      i_start  = 1'b1;
      i_we     = 1'b0;
      i_addr   = $urandom;
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         i_start = 1'b0;
         check("rst_pre_cyc", o_wb_cyc, 1);
      end
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      exp_rdata = '0;
      exp_err   = 1'b0;
      check("rst_cyc", o_wb_cyc, 0);
      check("rst_stb", o_wb_stb, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_rdata", o_rdata, 0);
   endtask

   initial begin
      logic [31:0] base;
      int r;
      int resp;
      repeat (3) @(negedge clk);
      check("reset_cyc", o_wb_cyc, 0);
      check("reset_stb", o_wb_stb, 0);
      check("reset_we", o_wb_we, 0);
      check("reset_adr", o_wb_adr, 0);
      check("reset_dat", o_wb_dat, 0);
      check("reset_sel", o_wb_sel, 0);
      check("reset_done", o_done, 0);
      check("reset_err", o_err, 0);
      check("reset_busy", o_busy, 0);
      check("reset_rdata", o_rdata, 0);
      i_rst = 1'b0;
      idle_cyc();

      run_cmd(1'b0, 32'h0000_1000, 32'h0, 0, R_ACK, 32'hDEAD_BEEF);
      idle_cyc();
      run_cmd(1'b1, 32'h0000_2004, 32'h1234_5678, 3, R_ACK, $urandom);
      idle_cyc();
      run_cmd(1'b0, 32'h0000_3000, 32'h0, 2, R_ERR, $urandom);
      idle_cyc();
      run_cmd(1'b0, 32'h0000_3004, 32'h0, 1, R_BOTH, $urandom);
      idle_cyc();
      run_cmd(1'b0, 32'h0000_4000, 32'h0, 0, R_SILENT, $urandom);
      idle_cyc();
      idle_cyc();

      base = 32'h0001_0000;
      for (int p = 0; p < 4; p++) begin
         run_cmd(1'b0, base + 32'(4 * p), 32'h0, 0, R_ACK, $urandom);
         run_cmd(1'b1, base + 32'(4 * p), $urandom, 0, R_ACK, $urandom);
      end
      idle_cyc();

      mid_reset();
      run_cmd(1'b0, 32'h0000_5003, 32'h0, 1, R_ACK, $urandom);
      idle_cyc();

      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 9);
         resp = (r == 6) ? R_ERR : (r == 7) ? R_BOTH : (r == 8) ? R_SILENT : R_ACK;
         run_cmd($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom_range(0, 6), resp,
                 $urandom);
         if ($urandom_range(0, 1) == 1) idle_cyc();
      end
      idle_cyc();
      idle_cyc();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
